// File: rtl/blink_round_ctrl.sv
// Purpose: iterative Blink block encryptor; one round datapath applies R NUM_ROUNDS times to a 64-bit state.
// Latency: out_valid rises NUM_ROUNDS edges after accept (NUM_ROUNDS/2 with BLINK_TWO_ROUND_EN defined).
// Backpressure: in_ready low outside IDLE; ciphertext held stable in DONE until out_ready is seen.
//
// Round R(tk, s): state is 16 nibbles, cell i = s[4i+3:4i], cell (row r, col c) = index 4r+c.
//   SubCells       : PRESENT 4-bit S-box on every cell.
//   MixColumns_AddKey : each cell becomes the XOR of the other three cells of its column, XOR tk cell.
//   ShuffleCells   : out cell i = in cell P[i], P = {0,10,5,15,14,4,11,1,9,3,12,6,7,13,2,8}.
// Optional macro BLINK_TWO_ROUND_EN: two chained rounds per cycle, same ciphertext.
module blink_round_ctrl #(
    parameter int         NUM_ROUNDS = 16,
    parameter logic [5:0] RC_INIT    = 6'b000001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [5:0]  round_idx
);

`ifdef BLINK_TWO_ROUND_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - STEP);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] blk;
    logic [63:0] key;
    logic [5:0]  rc;
    logic [63:0] blk_step;
    logic [5:0]  rc_step;
    logic        last_round;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic int shuf_src(input int i);
        case (i)
            0: shuf_src = 0;    1: shuf_src = 10;   2: shuf_src = 5;    3: shuf_src = 15;
            4: shuf_src = 14;   5: shuf_src = 4;    6: shuf_src = 11;   7: shuf_src = 1;
            8: shuf_src = 9;    9: shuf_src = 3;    10: shuf_src = 12;  11: shuf_src = 6;
            12: shuf_src = 7;   13: shuf_src = 13;  14: shuf_src = 2;   default: shuf_src = 8;
        endcase
    endfunction

    function automatic logic [63:0] round_fn(input logic [63:0] tk, input logic [63:0] s);
        logic [63:0] sc;
        logic [63:0] mc;
        logic [63:0] sh;
        logic [3:0]  par;
        for (int i = 0; i < 16; i++) begin
            sc[4*i +: 4] = sbox(s[4*i +: 4]);
        end
        // Column parity XOR own cell equals XOR of the other three cells.
        for (int c = 0; c < 4; c++) begin
            par = sc[4*c +: 4] ^ sc[4*(c+4) +: 4] ^ sc[4*(c+8) +: 4] ^ sc[4*(c+12) +: 4];
            for (int r = 0; r < 4; r++) begin
                mc[4*(4*r+c) +: 4] = par ^ sc[4*(4*r+c) +: 4] ^ tk[4*(4*r+c) +: 4];
            end
        end
        for (int i = 0; i < 16; i++) begin
            sh[4*i +: 4] = mc[4*shuf_src(i) +: 4];
        end
        return sh;
    endfunction

    function automatic logic [5:0] lfsr_next(input logic [5:0] x);
        return {x[4:0], x[5] ^ x[4]};
    endfunction

    // Round datapath: one or two chained R applications per cycle.
    always_comb begin
        logic [63:0] r1;
        logic [5:0]  rc1;
        r1 = round_fn(key ^ {58'b0, rc}, blk);
        rc1 = lfsr_next(rc);
`ifdef BLINK_TWO_ROUND_EN
        blk_step = round_fn(key ^ {58'b0, rc1}, r1);
        rc_step  = lfsr_next(rc1);
`else
        blk_step = r1;
        rc_step  = rc1;
`endif
        last_round = (round_idx == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)   state_nxt = S_RUN;
            S_RUN:   if (last_round) state_nxt = S_DONE;
            S_DONE:  if (out_ready)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only, no input-to-output path.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE:  in_ready = 1'b1;
            S_RUN:   busy = 1'b1;
            S_DONE:  begin out_valid = 1'b1; busy = 1'b1; end
            default: in_ready = 1'b0;
        endcase
    end

    // Block, key, round constant and round counter; key only loads on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk       <= 64'd0;
            key       <= 64'd0;
            rc        <= RC_INIT;
            round_idx <= 6'd0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    blk       <= in_data;
                    key       <= in_key;
                    rc        <= RC_INIT;
                    round_idx <= 6'd0;
                end
                S_RUN: begin
                    blk       <= blk_step;
                    rc        <= rc_step;
                    round_idx <= round_idx + 6'(STEP);
                end
                S_DONE: if (out_ready) round_idx <= 6'd0;
                default: round_idx <= 6'd0;
            endcase
        end
    end

    assign out_data = blk;

endmodule

// File: tb/tb_blink_round_ctrl.sv
module tb_blink_round_ctrl;
    localparam int         NR  = 16;
    localparam logic [5:0] RCI = 6'b000001;
`ifdef BLINK_TWO_ROUND_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int LAT = NR / STEP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = 64'd0;
    logic [63:0] in_key = 64'd0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [63:0] out_data;
    logic [5:0]  round_idx;

    int n_checks = 0;
    int n_pass = 0;

    int sb_tab[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    int perm[16]   = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};

    always #5 clk = ~clk;

    blink_round_ctrl #(.NUM_ROUNDS(NR), .RC_INIT(RCI)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round_idx(round_idx)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Reference: one round on a nibble array.
    function automatic logic [63:0] ref_round(input logic [63:0] s, input logic [63:0] tk);
        int a[16];
        int m[16];
        logic [63:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb_tab[int'(s[4*i +: 4])];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[4*r+c] = a[4*((r+1)%4)+c] ^ a[4*((r+2)%4)+c] ^ a[4*((r+3)%4)+c]
                           ^ int'(tk[4*(4*r+c) +: 4]);
        o = 64'd0;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = 4'(m[perm[i]]);
        return o;
    endfunction

    function automatic logic [63:0] ref_cipher(input logic [63:0] d, input logic [63:0] k);
        int rc;
        logic [63:0] s;
        rc = int'(RCI);
        s = d;
        for (int n = 0; n < NR; n++) begin
            s = ref_round(s, k ^ 64'(rc));
            rc = ((rc << 1) & 63) | (((rc >> 5) ^ (rc >> 4)) & 1);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a block and returns just after the accept edge.
    task automatic send(input logic [63:0] d, input logic [63:0] k, output bit ok);
        in_data = d;
        in_key = k;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            tick();
        end
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (round_idx !== 6'd0) $display("FAIL reset_round_idx: got %0d want 0", round_idx); else n_pass++;
        n_checks++; if (out_data !== 64'd0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    endtask

    task automatic test_zero_vector();
        bit ok;
        logic [63:0] exp;
        exp = ref_cipher(64'd0, 64'd0);
        out_ready = 1'b1;
        send(64'd0, 64'd0, ok);
        in_valid = 1'b0;
        n_checks++; if (!ok) $display("FAIL zero_accept: got no accept want accept"); else n_pass++;
        for (int e = 0; e < LAT; e++) begin
            n_checks++; if (round_idx !== 6'(e*STEP)) $display("FAIL zero_round_idx: got %0d want %0d", round_idx, e*STEP); else n_pass++;
            n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL zero_run_flags: got valid=%b busy=%b want 0/1", out_valid, busy); else n_pass++;
            tick();
        end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL zero_latency: got out_valid=%b want 1 after %0d edges", out_valid, LAT); else n_pass++;
        n_checks++; if (round_idx !== 6'(NR)) $display("FAIL zero_done_idx: got %0d want %0d", round_idx, NR); else n_pass++;
        n_checks++; if (out_data !== exp) $display("FAIL zero_data: got %h want %h", out_data, exp); else n_pass++;
        tick();
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || round_idx !== 6'd0) $display("FAIL zero_return_idle: got rdy=%b vld=%b idx=%0d want 1/0/0", in_ready, out_valid, round_idx); else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        int edges;
        logic [63:0] exp;
        exp = ref_cipher(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
        out_ready = 1'b0;
        send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, ok);
        in_valid = 1'b0;
        wait_out(edges);
        n_checks++; if (edges != LAT) $display("FAIL stall_latency: got %0d edges want %0d", edges, LAT); else n_pass++;
        in_valid = 1'b1;
        in_data = {$urandom, $urandom};
        in_key = {$urandom, $urandom};
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1 (cycle %0d)", out_valid, c); else n_pass++;
            n_checks++; if (out_data !== exp) $display("FAIL stall_data: got %h want %h (cycle %0d)", out_data, exp, c); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0 (cycle %0d)", in_ready, c); else n_pass++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int edges;
        logic [63:0] da, ka, db, kb;
        da = {$urandom, $urandom}; ka = {$urandom, $urandom};
        db = {$urandom, $urandom}; kb = {$urandom, $urandom};
        out_ready = 1'b1;
        send(da, ka, ok);
        in_data = db;
        in_key = kb;
        wait_out(edges);
        n_checks++; if (edges != LAT) $display("FAIL b2b_latency_a: got %0d want %0d", edges, LAT); else n_pass++;
        n_checks++; if (out_data !== ref_cipher(da, ka)) $display("FAIL b2b_data_a: got %h want %h", out_data, ref_cipher(da, ka)); else n_pass++;
        tick();
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_gap: got rdy=%b busy=%b want 1/0", in_ready, busy); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || round_idx !== 6'd0) $display("FAIL b2b_accept_b: got busy=%b idx=%0d want 1/0", busy, round_idx); else n_pass++;
        wait_out(edges);
        n_checks++; if (edges != LAT) $display("FAIL b2b_latency_b: got %0d want %0d", edges, LAT); else n_pass++;
        n_checks++; if (out_data !== ref_cipher(db, kb)) $display("FAIL b2b_data_b: got %h want %h", out_data, ref_cipher(db, kb)); else n_pass++;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int edges;
        int target;
        logic [63:0] d, k;
        target = (STEP == 1) ? 7 : 6;
        send({$urandom, $urandom}, {$urandom, $urandom}, ok);
        in_valid = 1'b0;
        for (int t = 0; t < 100 && round_idx !== 6'(target); t++) tick();
        n_checks++; if (round_idx !== 6'(target)) $display("FAIL abort_reach_idx: got %0d want %0d", round_idx, target); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abort_flags: got rdy=%b vld=%b busy=%b want 1/0/0", in_ready, out_valid, busy); else n_pass++;
        n_checks++; if (round_idx !== 6'd0 || out_data !== 64'd0) $display("FAIL abort_values: got idx=%0d data=%h want 0/0", round_idx, out_data); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        d = {$urandom, $urandom}; k = {$urandom, $urandom};
        send(d, k, ok);
        in_valid = 1'b0;
        wait_out(edges);
        n_checks++; if (edges != LAT) $display("FAIL abort_next_latency: got %0d want %0d", edges, LAT); else n_pass++;
        n_checks++; if (out_data !== ref_cipher(d, k)) $display("FAIL abort_next_data: got %h want %h", out_data, ref_cipher(d, k)); else n_pass++;
        // Reset while holding a finished block.
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 64'd0) $display("FAIL abort_done: got vld=%b data=%h want 0/0", out_valid, out_data); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit ok;
        int edges;
        int stall;
        logic [63:0] d, k, exp;
        for (int b = 0; b < 6; b++) begin
            d = {$urandom, $urandom}; k = {$urandom, $urandom};
            exp = ref_cipher(d, k);
            stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            send(d, k, ok);
            in_valid = 1'b0;
            n_checks++; if (!ok) $display("FAIL rand_accept: got no accept want accept (block %0d)", b); else n_pass++;
            wait_out(edges);
            n_checks++; if (edges != LAT) $display("FAIL rand_latency: got %0d want %0d (block %0d)", edges, LAT, b); else n_pass++;
            for (int s = 0; s <= stall; s++) begin
                n_checks++; if (out_data !== exp) $display("FAIL rand_data: got %h want %h (block %0d)", out_data, exp, b); else n_pass++;
                if (s < stall) tick();
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_zero_vector();
        test_stall();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
